hilo_sequencer: RTL and testbench

Control-side sequencer for the multicycle divider and owner of the architectural HI/LO registers. It sits between the control unit and the divider:
- accepts a divide request with operands;
- clears and starts the divider, then waits for its completion or divide-by-zero status;
- commits the quotient/remainder into LO/HI;
- services MTHI/MTLO writes;
- presents HI/LO for MFHI/MFLO and a busy stall for the pipeline/control FSM.

---
 rtl/hilo_sequencer.sv | 152 +++++++++++++++
 tb/tb_hilo_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hilo_sequencer
// Purpose : Divider control sequencer (clear/start/wait) and HI/LO owner.
// Revision: 1.0
// ============================================================================
module hilo_sequencer #(
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero,
  input  logic        div_end,
  output logic        div_rst,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        timeout,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam bit          c_wd_en  = (MAX_CYCLES != 0);
  localparam logic [31:0] c_max_m1 = 32'(MAX_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_cycles;
  logic        r_done;
  logic        r_dbz;
  logic        r_to;
  logic        w_accept;
  logic        w_zero;
  logic        w_end;
  logic        w_to;
  logic        w_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // WAIT outcome priority: divide-by-zero, then completion, then watchdog.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_zero    = 1'b0;
    w_end     = 1'b0;
    w_to      = 1'b0;
    div_rst   = 1'b0;
    div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_req) begin
          w_accept = 1'b1;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        div_rst = 1'b1;
        w_next  = S_START;
      end
      S_START: begin
        div_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (div_zero) begin
          w_zero = 1'b1;
          w_next = S_IDLE;
        end else if (div_end) begin
          w_end  = 1'b1;
          w_next = S_IDLE;
        end else if (c_wd_en && (r_count == c_max_m1)) begin
          w_to   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_exit = w_zero | w_end | w_to;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_cycles <= 32'd0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_done <= w_end;
      r_dbz  <= w_zero;
      r_to   <= w_to;
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_count <= 32'd0;
      end else if (r_state == S_IDLE) begin
        if (mthi) r_hi <= wr_data;
        if (mtlo) r_lo <= wr_data;
      end
      if ((r_state == S_WAIT) && !w_exit) r_count <= r_count + 32'd1;
      if (w_exit) r_cycles <= r_count + 32'd1;
      if (w_end) begin
        r_hi <= div_hi;
        r_lo <= div_lo;
      end
    end
  end

  assign div_a       = r_a;
  assign div_b       = r_b;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign cycles      = r_cycles;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign timeout     = r_to;

endmodule
`default_nettype wire

// File: tb/tb_hilo_sequencer.sv
`default_nettype none
// Bench for hilo_sequencer: behavioural divider plus elapsed-time reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hilo_sequencer;
  localparam int unsigned MAXC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req, mthi, mtlo, div_zero, div_end;
  logic [31:0] op_a, op_b, wr_data, div_hi, div_lo;
  logic        div_rst, div_start, busy, done, div_by_zero, timeout;
  logic [31:0] div_a, div_b, hi, lo, cycles;

  hilo_sequencer #(.MAX_CYCLES(MAXC)) u_dut (
    .clk(clk), .reset(reset), .div_req(div_req), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .div_hi(div_hi), .div_lo(div_lo),
    .div_zero(div_zero), .div_end(div_end), .div_rst(div_rst), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: m_t counts cycles since a request was accepted (0 = idle).
  int          m_t;
  int          m_n;
  logic [31:0] m_hi, m_lo, m_a, m_b, m_cyc;
  logic        m_done, m_dbz, m_to;
  logic [197:0] exp_v, act_v;

  // Divider stand-in: sticky end/zero flags, cleared by div_rst or reset.
  int          dcnt;
  int          lat_next = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] dv_a, dv_b;

  always @(negedge clk) begin
    if (reset) begin
      m_t = 0; m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_cyc = 0;
      m_done = 0; m_dbz = 0; m_to = 0;
    end
    exp_v = {m_t == 1, m_t == 2, m_t != 0, m_done, m_dbz, m_to, m_hi, m_lo, m_a, m_b, m_cyc};
    act_v = {div_rst, div_start, busy, done, div_by_zero, timeout, hi, lo, div_a, div_b, cycles};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
    if (reset) begin
      dcnt = 0; div_end = 0; div_zero = 0;
    end else begin
      if (div_rst) begin
        dcnt = 0; div_end = 0; div_zero = 0;
        div_hi = $urandom; div_lo = $urandom;
      end
      if (div_start) begin
        dv_a = div_a; dv_b = div_b;
        dcnt = rand_lat ? (($urandom % 8 == 0) ? 30 : int'($urandom_range(1, 6))) : lat_next;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_end  = 1'b1;
          div_zero = (dv_b == 32'd0);
          if (dv_b == 32'd0) begin
            div_hi = $urandom; div_lo = $urandom;
          end else if (dv_a == 32'h8000_0000 && dv_b == 32'hFFFF_FFFF) begin
            div_hi = 32'd0; div_lo = dv_a;
          end else begin
            div_lo = $signed(dv_a) / $signed(dv_b);
            div_hi = $signed(dv_a) % $signed(dv_b);
          end
        end
      end
      m_done = 0; m_dbz = 0; m_to = 0;
      if (m_t == 0) begin
        if (div_req) begin
          m_a = op_a; m_b = op_b; m_t = 1;
        end else begin
          if (mthi) m_hi = wr_data;
          if (mtlo) m_lo = wr_data;
        end
      end else if (m_t < 3) begin
        m_t++;
      end else begin
        m_n = m_t - 2;
        if (div_zero) begin
          m_dbz = 1; m_cyc = m_n; m_t = 0;
        end else if (div_end) begin
          m_done = 1; m_hi = div_hi; m_lo = div_lo; m_cyc = m_n; m_t = 0;
        end else if (MAXC != 0 && m_n == int'(MAXC)) begin
          m_to = 1; m_cyc = m_n; m_t = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) tick();
    check("busy_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input int lat);
    lat_next = lat;
    div_req = 1'b1; op_a = a; op_b = b;
    tick();
    div_req = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_a = $urandom; op_b = $urandom;
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; div_req = 0; mthi = 0; mtlo = 0;
    op_a = 0; op_b = 0; wr_data = 0; div_hi = 0; div_lo = 0; div_zero = 0; div_end = 0;
    repeat (3) tick();
    check("reset_hi", hi, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    op(32'd7, 32'd2, 1);
    check("7_2_done", {31'd0, done}, 32'd1);
    check("7_2_lo", lo, 32'd3);
    check("7_2_hi", hi, 32'd1);
    check("7_2_cycles", cycles, 32'd1);

    op(32'hFFFF_FFF9, 32'd2, 2);
    check("m7_2_lo", lo, 32'hFFFF_FFFD);
    op(32'd20, 32'd4, 3);
    check("20_4_lo", lo, 32'd5);
    check("20_4_hi", hi, 32'd0);
    check("20_4_cycles", cycles, 32'd3);

    op(32'd7, 32'd2, 1);
    op(32'd5, 32'd0, 2);
    check("dbz_pulse", {31'd0, div_by_zero}, 32'd1);
    check("dbz_no_done", {31'd0, done}, 32'd0);
    check("dbz_hi", hi, 32'd1);
    check("dbz_lo", lo, 32'd3);
    op(32'd9, 32'd3, 1);
    check("9_3_lo", lo, 32'd3);
    check("9_3_hi", hi, 32'd0);

    mthi = 1; wr_data = 32'hDEAD_BEEF;
    tick();
    mthi = 0; mtlo = 1; wr_data = 32'h1234_5678;
    tick();
    mtlo = 0;
    check("mthi", hi, 32'hDEAD_BEEF);
    check("mtlo", lo, 32'h1234_5678);
    mthi = 1; mtlo = 1; wr_data = 32'hA5A5_0F0F;
    tick();
    mthi = 0; mtlo = 1; wr_data = 32'h0000_0000;
    check("mt_both", hi ^ lo, 32'd0);
    lat_next = 3;
    div_req = 1; op_a = 32'd30; op_b = 32'd5;
    tick();
    div_req = 0; mtlo = 0;
    check("mtlo_dropped", lo, 32'hA5A5_0F0F);
    wait_idle();
    check("30_5_lo", lo, 32'd6);

    op(32'd100, 32'd1, 40);
    check("wd_timeout", {31'd0, timeout}, 32'd1);
    check("wd_cycles", cycles, 32'd4);
    check("wd_lo", lo, 32'd6);

    lat_next = 40;
    div_req = 1; op_a = 32'd100; op_b = 32'd1;
    tick();
    div_req = 0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_a", div_a, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_done", {31'd0, done}, 32'd0);
    op(32'd7, 32'd2, 1);
    check("post_rst_lo", lo, 32'd3);

    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      div_req = ($urandom % 4 == 0);
      mthi    = ($urandom % 5 == 0);
      mtlo    = ($urandom % 5 == 0);
      wr_data = $urandom;
      op_a    = $urandom;
      op_b    = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      reset   = ($urandom % 300 == 0);
      tick();
    end
    div_req = 0; mthi = 0; mtlo = 0; reset = 0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
